mips_regfile: RTL and testbench

Architectural 32×32-bit general-purpose register file for the OpenMIPS five-stage pipeline; it is the responder to the decode stage's two register-read requests and the sink of the write-back stage's single write port. Reads are combinational so decode receives operands in the same cycle it presents addresses. Writes commit on the rising clock edge. After reset a sweep state machine clears every register, one per cycle, and signals readiness to the pipeline control.

---
 rtl/mips_regfile.sv | 135 +++++++++++++
 tb/tb_mips_regfile.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// Architectural 32x32 register file: two combinational read ports, one write
// port, and a post-reset clear sweep. Optional macro: REGFILE_WB_BYPASS_EN.
module mips_regfile #(
  parameter int REG_NUM = 32,
  parameter int REG_W   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [REG_W-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata2,
  output logic              ready_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [REG_W-1:0]  regs_q [REG_NUM];

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [REG_W-1:0]  wr_data_s;

  // State, sweep counter and ready flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= ZERO_IDX;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: sweep one register per cycle, enter RUN after the last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = ZERO_IDX;
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          ready_d = 1'b0;
        end
      end
      RUN: begin
        state_d = RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = ZERO_IDX;
        ready_d = 1'b0;
      end
    endcase
  end

  // Write-port control: sweep clears own the port in CLEAR, write-back gets it in RUN
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = ZERO_IDX;
    wr_data_s = '0;
    if (rst) begin
      wr_en_s = 1'b0;
    end else if (state_q == CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cnt_q;
      wr_data_s = '0;
    end else if (we && (waddr != ZERO_IDX)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = waddr;
      wr_data_s = wdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array storage
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      regs_q[wr_addr_s] <= wr_data_s;
    end
  end

  function automatic logic [REG_W-1:0] read_port(input logic              re_n,
                                                  input logic [ADDR_W-1:0] raddr_n);
    logic [REG_W-1:0] val;
    if (rst || (state_q == CLEAR)) begin
      val = '0;
    end else if (!re_n) begin
      val = '0;
    end else if (raddr_n == ZERO_IDX) begin
      val = '0;
`ifdef REGFILE_WB_BYPASS_EN
    // Write-through closes the WB->ID same-cycle hazard
    end else if (we && (waddr == raddr_n)) begin
      val = wdata;
`endif
    end else begin
      val = regs_q[raddr_n];
    end
    return val;
  endfunction

  // Combinational read ports
  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  assign ready_o = ready_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile; hazard expectation follows
// whether REGFILE_WB_BYPASS_EN is defined.
module tb_mips_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ready_o;

  int checks;
  int failures;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic [31:0] HAZ_EXP = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] HAZ_EXP = 32'h0000_0001;
`endif

  mips_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .ready_o(ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    we     = 1'b0;
    waddr  = 5'd0;
    wdata  = 32'h0;
    re1    = 1'b1;
    raddr1 = 5'd7;
    re2    = 1'b1;
    raddr2 = 5'd3;

    // Initial reset and sweep
    repeat (3) step();
    check("reset_ready", {31'd0, ready_o}, 32'h0);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 40 && !ready_o; i++) step();
    check("sweep1_ready", {31'd0, ready_o}, 32'h1);

    // Seed r7 before the second reset
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
    #1;
    check("r7_seeded", rdata1, 32'hDEAD_BEEF);

    // Reset for 3 cycles, then count sweep edges; write attempted at sweep edge 10
    rst = 1'b1;
    repeat (3) step();
    check("reset2_ready", {31'd0, ready_o}, 32'h0);
    check("reset2_rdata1", rdata1, 32'h0);
    rst = 1'b0;
    raddr2 = 5'd3;
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0055;
        #1;
        check("clear_we_rdata2", rdata2, 32'h0);
      end
      step();
      we = 1'b0;
      #1;
      check($sformatf("sweep_ready_e%0d", k), {31'd0, ready_o}, (k == 32) ? 32'h1 : 32'h0);
      if (k < 32) begin
        check($sformatf("clear_rdata1_e%0d", k), rdata1, 32'h0);
        check($sformatf("clear_rdata2_e%0d", k), rdata2, 32'h0);
      end
    end
    check("r7_cleared", rdata1, 32'h0);
    check("r3_dropped", rdata2, 32'h0);

    // Write then read r5, with and without read enable
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
    step();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    check("r5_read", rdata1, 32'h1234_5678);
    re1 = 1'b0;
    #1;
    check("r5_re1_low", rdata1, 32'h0);

    // Zero register stays zero
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    check("r0_same_cycle_p1", rdata1, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("r0_p1", rdata1, 32'h0);
    check("r0_p2", rdata2, 32'h0);

    // Same-cycle WB->ID hazard on r9
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0001;
    step();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9;
    #1;
    check("hazard_p2", rdata2, HAZ_EXP);
    check("hazard_p1", rdata1, HAZ_EXP);
    re2 = 1'b0;
    #1;
    check("hazard_re2_low", rdata2, 32'h0);
    step();
    we = 1'b0; re2 = 1'b1;
    #1;
    check("r9_after_p1", rdata1, 32'hA5A5_A5A5);
    check("r9_after_p2", rdata2, 32'hA5A5_A5A5);

    // Reset asserted mid-sweep restarts the full 32-edge sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    check("mid_sweep_ready", {31'd0, ready_o}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("resweep_ready_e%0d", k), {31'd0, ready_o}, (k == 32) ? 32'h1 : 32'h0);
    end
    check("resweep_r9", rdata1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
